// File: rtl/alt_cv_gbt_pll_pkg.sv
// Shared types and helpers for the GBT frame-clock PLL lock manager.
package alt_cv_gbt_pll_pkg;

  typedef enum logic [1:0] {
    RST_PULSE = 2'd0,
    WAIT_LOCK = 2'd1,
    LOCKED    = 2'd2,
    FAILED    = 2'd3
  } pll_state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/alt_cv_gbt_pll_lock_chan.sv
// One PLL channel: locked synchroniser, reset-pulse/lock-wait FSM, retry budget
// and saturating lock-loss counter.
module alt_cv_gbt_pll_lock_chan
  import alt_cv_gbt_pll_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked_i,
  input  logic                  sw_reset_i,
  input  logic                  clr_cnt_i,
  output logic                  pll_rst_o,
  output logic                  ready_o,
  output logic                  fail_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int PW = cnt_w(RST_PULSE_CYCLES);
  localparam int FW = cnt_w(LOCK_FILTER_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int RW = cnt_w(MAX_RETRIES);

  localparam logic [PW-1:0]         PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [FW-1:0]         FILT_LAST  = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [TW-1:0]         TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]         RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE   = LOSS_CNT_W'(1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_locked_s;
  logic                  w_loss_evt;
  pll_state_e            r_state;
  logic [PW-1:0]         r_pulse_cnt;
  logic [FW-1:0]         r_filter;
  logic [TW-1:0]         r_timer;
  logic [RW-1:0]         r_retry;
  logic                  r_pll_rst;
  logic                  r_ready;
  logic                  r_fail;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_locked_s = r_sync2;
  assign w_loss_evt = (r_state == LOCKED) && !w_locked_s;

  // A loss coinciding with a clear must leave exactly one event recorded.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt) begin
      if (clr_cnt_i)
        r_loss_cnt <= LOSS_ONE;
      else if (!(&r_loss_cnt))
        r_loss_cnt <= r_loss_cnt + LOSS_ONE;
    end else if (clr_cnt_i) begin
      r_loss_cnt <= '0;
    end
  end

  // Filter and timeout compare against N-1 so the transition lands on the Nth counted cycle.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_PULSE;
      r_pulse_cnt <= '0;
      r_filter    <= '0;
      r_timer     <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else if (sw_reset_i) begin
      r_state     <= RST_PULSE;
      r_pulse_cnt <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      case (r_state)
        RST_PULSE: begin
          if (r_pulse_cnt == PULSE_LAST) begin
            r_state   <= WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_timer   <= '0;
            r_filter  <= '0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + PW'(1);
          end
        end
        WAIT_LOCK: begin
          r_timer  <= r_timer + TW'(1);
          r_filter <= w_locked_s ? r_filter + FW'(1) : '0;
          if (w_locked_s && (r_filter == FILT_LAST)) begin
            r_state <= LOCKED;
            r_ready <= 1'b1;
            r_retry <= '0;
          end else if (r_timer == TMO_LAST) begin
            if (r_retry < RETRY_MAX) begin
              r_retry     <= r_retry + RW'(1);
              r_state     <= RST_PULSE;
              r_pulse_cnt <= '0;
              r_pll_rst   <= 1'b1;
            end else begin
              r_state <= FAILED;
              r_fail  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (!w_locked_s) begin
            r_state     <= RST_PULSE;
            r_pulse_cnt <= '0;
            r_pll_rst   <= 1'b1;
            r_ready     <= 1'b0;
          end
        end
        FAILED: begin
          r_pll_rst <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst_o     = r_pll_rst;
  assign ready_o       = r_ready;
  assign fail_o        = r_fail;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: rtl/alt_cv_gbt_pll_lock_mgr.sv
// Lock manager for NUM_PLLS independent frame-clock PLLs with an aggregate ready.
module alt_cv_gbt_pll_lock_mgr
  import alt_cv_gbt_pll_pkg::*;
#(
  parameter int NUM_PLLS            = 1,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic [NUM_PLLS-1:0]            pll_locked_i,
  input  logic [NUM_PLLS-1:0]            sw_reset_i,
  input  logic                           clr_cnt_i,
  output logic [NUM_PLLS-1:0]            pll_rst_o,
  output logic [NUM_PLLS-1:0]            ready_o,
  output logic [NUM_PLLS-1:0]            fail_o,
  output logic                           all_ready_o,
  output logic [NUM_PLLS*LOSS_CNT_W-1:0] lock_loss_cnt
);

  logic r_all_ready;

  for (genvar g = 0; g < NUM_PLLS; g++) begin : g_chan
    alt_cv_gbt_pll_lock_chan #(
      .RST_PULSE_CYCLES    (RST_PULSE_CYCLES),
      .LOCK_FILTER_CYCLES  (LOCK_FILTER_CYCLES),
      .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
      .MAX_RETRIES         (MAX_RETRIES),
      .LOSS_CNT_W          (LOSS_CNT_W)
    ) u_chan (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .pll_locked_i  (pll_locked_i[g]),
      .sw_reset_i    (sw_reset_i[g]),
      .clr_cnt_i     (clr_cnt_i),
      .pll_rst_o     (pll_rst_o[g]),
      .ready_o       (ready_o[g]),
      .fail_o        (fail_o[g]),
      .lock_loss_cnt (lock_loss_cnt[g*LOSS_CNT_W +: LOSS_CNT_W])
    );
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      r_all_ready <= 1'b0;
    else
      r_all_ready <= &ready_o;
  end

  assign all_ready_o = r_all_ready;

endmodule

// File: tb/tb_alt_cv_gbt_pll_lock_mgr.sv
// Self-checking bench for alt_cv_gbt_pll_lock_mgr with a timeline-based reference model.
module tb_alt_cv_gbt_pll_lock_mgr;

  localparam int NP = 2;
  localparam int RP = 4;
  localparam int FC = 8;
  localparam int TO = 32;
  localparam int MR = 2;
  localparam int LW = 4;
  localparam int VW = 3*NP + 1 + NP*LW;
  localparam int LSAT = (1 << LW) - 1;

  logic              refclk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NP-1:0]     pll_locked_i = '0;
  logic [NP-1:0]     sw_reset_i = '0;
  logic              clr_cnt_i = 1'b0;
  logic [NP-1:0]     pll_rst_o;
  logic [NP-1:0]     ready_o;
  logic [NP-1:0]     fail_o;
  logic              all_ready_o;
  logic [NP*LW-1:0]  lock_loss_cnt;
  logic [VW-1:0]     act;

  int total = 0;
  int bad = 0;

  // Reference model: remaining pulse cycles, cycles spent waiting, consecutive
  // high run seen through the 2-cycle synchroniser delay, retries used.
  int m_pulse_left[NP];
  int m_waited[NP];
  int m_run[NP];
  int m_tries[NP];
  int m_loss[NP];
  bit m_rst[NP];
  bit m_ready[NP];
  bit m_fail[NP];
  bit m_h1[NP];
  bit m_h2[NP];
  bit m_all;

  alt_cv_gbt_pll_lock_mgr #(
    .NUM_PLLS            (NP),
    .RST_PULSE_CYCLES    (RP),
    .LOCK_FILTER_CYCLES  (FC),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR),
    .LOSS_CNT_W          (LW)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked_i  (pll_locked_i),
    .sw_reset_i    (sw_reset_i),
    .clr_cnt_i     (clr_cnt_i),
    .pll_rst_o     (pll_rst_o),
    .ready_o       (ready_o),
    .fail_o        (fail_o),
    .all_ready_o   (all_ready_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  assign act = {pll_rst_o, ready_o, fail_o, all_ready_o, lock_loss_cnt};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic model_reset();
    for (int ch = 0; ch < NP; ch++) begin
      m_rst[ch] = 1'b1;
      m_pulse_left[ch] = RP;
      m_waited[ch] = 0;
      m_run[ch] = 0;
      m_tries[ch] = 0;
      m_loss[ch] = 0;
      m_ready[ch] = 1'b0;
      m_fail[ch] = 1'b0;
      m_h1[ch] = 1'b0;
      m_h2[ch] = 1'b0;
    end
    m_all = 1'b0;
  endtask

  task automatic start_pulse(input int ch);
    m_rst[ch] = 1'b1;
    m_pulse_left[ch] = RP;
  endtask

  task automatic model_step();
    bit all_nx;
    all_nx = 1'b1;
    for (int ch = 0; ch < NP; ch++) all_nx = all_nx & m_ready[ch];
    for (int ch = 0; ch < NP; ch++) begin
      bit seen;
      bit loss_evt;
      seen = m_h2[ch];
      m_h2[ch] = m_h1[ch];
      m_h1[ch] = pll_locked_i[ch];
      loss_evt = m_ready[ch] && !seen;
      if (clr_cnt_i) m_loss[ch] = loss_evt ? 1 : 0;
      else if (loss_evt && m_loss[ch] < LSAT) m_loss[ch]++;
      if (sw_reset_i[ch]) begin
        m_ready[ch] = 1'b0;
        m_fail[ch] = 1'b0;
        m_tries[ch] = 0;
        start_pulse(ch);
      end else if (m_pulse_left[ch] > 0) begin
        m_pulse_left[ch]--;
        if (m_pulse_left[ch] == 0) begin
          m_rst[ch] = 1'b0;
          m_waited[ch] = 0;
          m_run[ch] = 0;
        end
      end else if (m_ready[ch]) begin
        if (!seen) begin
          m_ready[ch] = 1'b0;
          start_pulse(ch);
        end
      end else if (!m_fail[ch]) begin
        m_waited[ch]++;
        m_run[ch] = seen ? m_run[ch] + 1 : 0;
        if (m_run[ch] == FC) begin
          m_ready[ch] = 1'b1;
          m_tries[ch] = 0;
        end else if (m_waited[ch] == TO) begin
          if (m_tries[ch] < MR) begin
            m_tries[ch]++;
            start_pulse(ch);
          end else begin
            m_fail[ch] = 1'b1;
          end
        end
      end
    end
    m_all = all_nx;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NP-1:0]    r;
    logic [NP-1:0]    rd;
    logic [NP-1:0]    f;
    logic [NP*LW-1:0] l;
    for (int ch = 0; ch < NP; ch++) begin
      r[ch] = m_rst[ch];
      rd[ch] = m_ready[ch];
      f[ch] = m_fail[ch];
      l[ch*LW +: LW] = LW'(m_loss[ch]);
    end
    return {r, rd, f, m_all, l};
  endfunction

  task automatic cycle();
    @(posedge refclk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    total++; if (pll_rst_o !== 2'b11) begin bad++; $display("FAIL reset_pll_rst: got=%b want=11", pll_rst_o); end
    total++; if ({ready_o, fail_o, all_ready_o} !== 5'b0) begin bad++; $display("FAIL reset_flags: got=%b want=00000", {ready_o, fail_o, all_ready_o}); end
    total++; if (lock_loss_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got=%h want=0", lock_loss_cnt); end
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL reset_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      total++; if (pll_rst_o !== ((k <= RP - 1) ? 2'b11 : 2'b00)) begin bad++; $display("FAIL release_pulse k=%0d: got=%b", k, pll_rst_o); end
    end
  endtask

  task automatic test_filter();
    int n;
    n = 0;
    repeat ($urandom_range(1, 3)) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL filter_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
    end
    pll_locked_i[0] = 1'b1;
    repeat (5) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL filter_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
    end
    pll_locked_i[0] = 1'b0;
    cycle();
    total++; if (act !== exp_vec()) begin bad++; $display("FAIL filter_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
    pll_locked_i[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL filter_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      if (n == 0 && ready_o[0] === 1'b1) n = i;
    end
    total++; if (n != 2 + FC) begin bad++; $display("FAIL ready_latency: got=%0d want=%0d", n, 2 + FC); end
    total++; if (all_ready_o !== 1'b0) begin bad++; $display("FAIL all_ready_early: got=%b want=0", all_ready_o); end
  endtask

  task automatic test_retry();
    int  rises;
    int  last_rise;
    bit  prev;
    bit  done;
    bit  stuck;
    rises = 0;
    last_rise = 0;
    done = 0;
    stuck = 0;
    prev = pll_rst_o[1];
    for (int i = 1; i <= 200 && !done; i++) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL retry_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      if (!prev && pll_rst_o[1]) begin
        rises++;
        if (rises > 1) begin
          total++; if (i - last_rise != RP + TO) begin bad++; $display("FAIL retry_spacing: got=%0d want=%0d", i - last_rise, RP + TO); end
        end
        last_rise = i;
      end
      if (prev && !pll_rst_o[1] && last_rise != 0) begin
        total++; if (i - last_rise != RP) begin bad++; $display("FAIL retry_pulse_len: got=%0d want=%0d", i - last_rise, RP); end
      end
      prev = pll_rst_o[1];
      if (fail_o[1] === 1'b1) done = 1;
    end
    total++; if (!done) begin bad++; $display("FAIL retry_fail_timeout: got=no fail want=fail"); end
    total++; if (rises != MR) begin bad++; $display("FAIL retry_count: got=%0d want=%0d", rises, MR); end
    for (int i = 0; i < 40; i++) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL retry_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      if (pll_rst_o[1] !== 1'b0 || fail_o[1] !== 1'b1) stuck = 1;
    end
    total++; if (stuck) begin bad++; $display("FAIL failed_hold: got=left FAILED want=stay"); end
    total++; if (all_ready_o !== 1'b0) begin bad++; $display("FAIL all_ready_with_fail: got=%b want=0", all_ready_o); end
  endtask

  task automatic test_loss();
    int hold;
    int exp_l;
    for (int it = 1; it <= 20; it++) begin
      hold = $urandom_range(1, 3);
      exp_l = (it > LSAT) ? LSAT : it;
      pll_locked_i[0] = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        cycle();
        total++; if (act !== exp_vec()) begin bad++; $display("FAIL loss_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
        if (i == hold) pll_locked_i[0] = 1'b1;
        if (i == 2) begin
          total++; if (ready_o[0] !== 1'b1) begin bad++; $display("FAIL loss_early_drop it=%0d: got=%b want=1", it, ready_o[0]); end
        end
      end
      total++; if (ready_o[0] !== 1'b0) begin bad++; $display("FAIL loss_drop it=%0d: got=%b want=0", it, ready_o[0]); end
      total++; if (pll_rst_o[0] !== 1'b1) begin bad++; $display("FAIL loss_pulse it=%0d: got=%b want=1", it, pll_rst_o[0]); end
      total++; if (lock_loss_cnt[LW-1:0] !== LW'(exp_l)) begin bad++; $display("FAIL loss_cnt it=%0d: got=%0d want=%0d", it, lock_loss_cnt[LW-1:0], exp_l); end
      for (int i = 0; i < 40 && ready_o[0] !== 1'b1; i++) begin
        cycle();
        total++; if (act !== exp_vec()) begin bad++; $display("FAIL loss_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      end
      total++; if (ready_o[0] !== 1'b1) begin bad++; $display("FAIL loss_relock it=%0d: got=%b want=1", it, ready_o[0]); end
    end
  endtask

  task automatic test_sw_clr();
    int since;
    bit done;
    sw_reset_i[1] = 1'b1;
    clr_cnt_i = 1'b1;
    cycle();
    sw_reset_i[1] = 1'b0;
    clr_cnt_i = 1'b0;
    total++; if (act !== exp_vec()) begin bad++; $display("FAIL swclr_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
    total++; if (fail_o[1] !== 1'b0) begin bad++; $display("FAIL sw_fail_drop: got=%b want=0", fail_o[1]); end
    total++; if (pll_rst_o[1] !== 1'b1) begin bad++; $display("FAIL sw_pulse: got=%b want=1", pll_rst_o[1]); end
    total++; if (lock_loss_cnt !== '0) begin bad++; $display("FAIL clr_cnt: got=%h want=0", lock_loss_cnt); end
    since = 0;
    done = 0;
    for (int i = 0; i < 150 && !done; i++) begin
      cycle();
      since++;
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL swclr_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      if (fail_o[1] === 1'b1) done = 1;
    end
    total++; if (!done || since != (MR + 1) * (RP + TO)) begin bad++; $display("FAIL retry_budget: got=%0d want=%0d", since, (MR + 1) * (RP + TO)); end

    for (int pass = 0; pass < 3; pass++) begin
      pll_locked_i[0] = 1'b0;
      cycle();
      pll_locked_i[0] = 1'b1;
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL swclr_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL swclr_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      if (pass == 1) clr_cnt_i = 1'b1;
      if (pass == 2) sw_reset_i[0] = 1'b1;
      cycle();
      clr_cnt_i = 1'b0;
      sw_reset_i[0] = 1'b0;
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL swclr_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      total++; if (lock_loss_cnt[LW-1:0] !== LW'(pass == 2 ? 2 : 1)) begin bad++; $display("FAIL loss_vs_clr_sw pass=%0d: got=%0d want=%0d", pass, lock_loss_cnt[LW-1:0], pass == 2 ? 2 : 1); end
      total++; if (ready_o[0] !== 1'b0 || pll_rst_o[0] !== 1'b1) begin bad++; $display("FAIL loss_restart pass=%0d: got ready=%b rst=%b want ready=0 rst=1", pass, ready_o[0], pll_rst_o[0]); end
      if (pass < 2) begin
        for (int i = 0; i < 40 && ready_o[0] !== 1'b1; i++) begin
          cycle();
          total++; if (act !== exp_vec()) begin bad++; $display("FAIL swclr_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 40 && ready_o[0] !== 1'b1; i++) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL async_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
    end
    sw_reset_i[1] = 1'b1;
    cycle();
    sw_reset_i[1] = 1'b0;
    repeat (RP + 3) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL async_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
    end
    total++; if (ready_o[0] !== 1'b1 || pll_rst_o[1] !== 1'b0) begin bad++; $display("FAIL async_precond: got ready0=%b rst1=%b want 1 0", ready_o[0], pll_rst_o[1]); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (act !== {2'b11, 2'b00, 2'b00, 1'b0, 8'h00}) begin bad++; $display("FAIL async_reset_vals: got=%h want=%h", act, {2'b11, 2'b00, 2'b00, 1'b0, 8'h00}); end
    model_reset();
    repeat (2) @(posedge refclk);
    #1;
    rst_n = 1'b1;
    pll_locked_i = '1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL async_model: got=%h want=%h t=%0t", act, exp_vec(), $time); end
      if (all_ready_o === 1'b1) n = i;
    end
    total++; if (n != RP + FC + 1) begin bad++; $display("FAIL restart_all_ready: got=%0d want=%0d", n, RP + FC + 1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < NP; ch++) begin
        if ($urandom_range(0, 15) == 0) pll_locked_i[ch] = ~pll_locked_i[ch];
        sw_reset_i[ch] = ($urandom_range(0, 99) == 0);
      end
      clr_cnt_i = ($urandom_range(0, 63) == 0);
      cycle();
      total++; if (act !== exp_vec()) begin bad++; $display("FAIL random_model i=%0d: got=%h want=%h", i, act, exp_vec()); end
    end
    sw_reset_i = '0;
    clr_cnt_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_filter();
    test_retry();
    test_loss();
    test_sw_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
